// File: rtl/matrix_multiplication_seq.sv
// Sequential fixed-point matrix multiplier C = A * B with runtime dimensions and LANES parallel MACs.
// Optional MATMUL_SAT_EN: clamp results to the DATA_W signed range instead of wrapping.
module matrix_multiplication_seq #(
  parameter int LBUF   = 3,
  parameter int MBUF   = 3,
  parameter int NBUF   = 3,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int LANES  = 1,
  parameter int DIM_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIM_W-1:0]              l,
  input  logic [DIM_W-1:0]              m,
  input  logic [DIM_W-1:0]              n,
  input  logic [DATA_W*LBUF*MBUF-1:0]   A,
  input  logic [DATA_W*NBUF*MBUF-1:0]   B_T,
  output logic [DATA_W*LBUF*NBUF-1:0]   result,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  localparam int ACC_W = 2*DATA_W + $clog2(MBUF) + 1;

  typedef enum logic [1:0] {IDLE, MAC, WR, FIN} state_t;

  state_t                          state_reg, state_next;
  logic [DATA_W*LBUF*MBUF-1:0]     a_reg;
  logic [DATA_W*NBUF*MBUF-1:0]     b_reg;
  logic [DIM_W-1:0]                l_reg, m_reg, n_reg;
  logic [DIM_W-1:0]                i_reg, j_reg, k_reg;
  logic signed [ACC_W-1:0]         acc_reg;
  logic [DATA_W*LBUF*NBUF-1:0]     result_reg;
  logic                            err_reg;
  logic                            run_en_reg;

  logic                            dims_ok, last_k, last_j, last_i;
  logic signed [2*DATA_W-1:0]      lane_prod [LANES];
  logic signed [ACC_W-1:0]         lane_sum;
  logic [DATA_W-1:0]               elem;

  assign dims_ok = (l != '0) && (m != '0) && (n != '0) &&
                   (l <= DIM_W'(LBUF)) && (m <= DIM_W'(MBUF)) && (n <= DIM_W'(NBUF));
  assign last_k  = (k_reg + DIM_W'(LANES)) >= m_reg;
  assign last_j  = j_reg == (n_reg - 1'b1);
  assign last_i  = i_reg == (l_reg - 1'b1);

  // Each lane handles inner index k+gi; lanes past m contribute nothing.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [DIM_W-1:0] OFS = DIM_W'(gi);
    logic [DIM_W-1:0]           kp, a_idx, b_idx;
    logic                       lane_valid;
    logic signed [DATA_W-1:0]   a_el, b_el;
    logic signed [2*DATA_W-1:0] prod;

    assign kp         = k_reg + OFS;
    assign lane_valid = kp < m_reg;
    assign a_idx      = lane_valid ? (i_reg * m_reg + kp) : '0;
    assign b_idx      = lane_valid ? (j_reg * m_reg + kp) : '0;
    assign a_el       = a_reg[DATA_W*a_idx +: DATA_W];
    assign b_el       = b_reg[DATA_W*b_idx +: DATA_W];
    assign prod       = (2*DATA_W)'(a_el) * (2*DATA_W)'(b_el);
    assign lane_prod[gi] = lane_valid ? prod : '0;
  end

  always_comb begin
    lane_sum = '0;
    for (int p = 0; p < LANES; p++) begin
      lane_sum = lane_sum + ACC_W'(lane_prod[p]);
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc_reg >>> FRAC_W;

  always_comb begin
    elem = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      elem = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      elem = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  // Low DATA_W bits of the arithmetic shift are exactly this slice.
  assign elem = acc_reg[FRAC_W +: DATA_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start && run_en_reg) state_next = dims_ok ? MAC : FIN;
      MAC: begin
        busy = 1'b1;
        if (last_k) state_next = WR;
      end
      WR: begin
        busy       = 1'b1;
        state_next = (last_j && last_i) ? FIN : MAC;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // run_en_reg masks a start arriving on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      l_reg      <= '0;
      m_reg      <= '0;
      n_reg      <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      run_en_reg <= 1'b0;
    end else begin
      run_en_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start && run_en_reg) begin
            a_reg      <= A;
            b_reg      <= B_T;
            l_reg      <= l;
            m_reg      <= m;
            n_reg      <= n;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            err_reg    <= !dims_ok;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + lane_sum;
          k_reg   <= k_reg + DIM_W'(LANES);
        end
        WR: begin
          result_reg[DATA_W*(i_reg*n_reg + j_reg) +: DATA_W] <= elem;
          acc_reg <= '0;
          k_reg   <= '0;
          if (last_j) begin
            j_reg <= '0;
            i_reg <= i_reg + 1'b1;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_matrix_multiplication_seq.sv
// Randomized self-checking bench for matrix_multiplication_seq against a plain-arithmetic reference model.
module tb_matrix_multiplication_seq;
  localparam int LB = 3, MB = 3, NB = 3, DW = 16, FW = 8, LN = 2, DIMW = 32;
  localparam int AW = DW*LB*MB, BW = DW*NB*MB, RW = DW*LB*NB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [DIMW-1:0] l_in = '0, m_in = '0, n_in = '0;
  logic [AW-1:0]   a_in = '0;
  logic [BW-1:0]   b_in = '0;
  logic [RW-1:0]   result;
  logic            busy, done, err;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] ma [LB][MB];
  logic signed [DW-1:0] mb [MB][NB];

  matrix_multiplication_seq #(
    .LBUF(LB), .MBUF(MB), .NBUF(NB), .DATA_W(DW), .FRAC_W(FW), .LANES(LN), .DIM_W(DIMW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .l(l_in), .m(m_in), .n(n_in),
    .A(a_in), .B_T(b_in), .result(result), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_el();
    logic [DW-1:0] v;
    if ($urandom_range(0, 1) == 1) v = DW'($urandom);
    else v = (DW'($urandom_range(0, 8)) - DW'(4)) << FW;
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < LB; i++) for (int k = 0; k < MB; k++) ma[i][k] = rnd_el();
    for (int k = 0; k < MB; k++) for (int j = 0; j < NB; j++) mb[k][j] = rnd_el();
  endtask

  // C(i,j) = sum_k A(i,k)*B(k,j), rescaled by 2^-FW (floor), then reduced to DW bits.
  function automatic logic [RW-1:0] model(input int l, input int m, input int n);
    logic [RW-1:0] r;
    longint acc;
    r = '0;
    for (int i = 0; i < l; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < m; k++) acc += longint'(ma[i][k]) * longint'(mb[k][j]);
        acc = acc >>> FW;
`ifdef MATMUL_SAT_EN
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        r[DW*(i*n+j) +: DW] = acc[DW-1:0];
      end
    end
    return r;
  endfunction

  task automatic pack(input int l, input int m, input int n, input bit bad);
    for (int x = 0; x < LB*MB; x++) a_in[DW*x +: DW] = DW'($urandom);
    for (int x = 0; x < NB*MB; x++) b_in[DW*x +: DW] = DW'($urandom);
    if (!bad) begin
      for (int i = 0; i < l; i++) for (int k = 0; k < m; k++) a_in[DW*(i*m+k) +: DW] = ma[i][k];
      for (int j = 0; j < n; j++) for (int k = 0; k < m; k++) b_in[DW*(j*m+k) +: DW] = mb[k][j];
    end
  endtask

  task automatic run_job(input int l, input int m, input int n, input bit disturb, input string tag);
    logic [RW-1:0] exp;
    bit bad;
    int lat_exp, cyc, busy_cnt;
    bad = (l == 0) || (m == 0) || (n == 0) || (l > LB) || (m > MB) || (n > NB);
    @(negedge clk);
    l_in = l; m_in = m; n_in = n;
    pack(l, m, n, bad);
    exp     = bad ? '0 : model(l, m, n);
    lat_exp = bad ? 1 : l*n*((m+LN-1)/LN + 1) + 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 300) begin
      if (busy) busy_cnt++;
      if (disturb && cyc == 3) begin
        a_in = ~a_in; b_in = ~b_in; l_in = 1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    $display("job %s l=%0d m=%0d n=%0d latency=%0d err=%0b", tag, l, m, n, cyc, err);
    check({tag, ".latency"}, cyc, lat_exp);
    check({tag, ".busy_cycles"}, busy_cnt, lat_exp - 1);
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".err"}, err, bad);
    check({tag, ".result"}, result, exp);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".hold"}, result, exp);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    check("reset.result", result, '0);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    l_in = 1; m_in = 1; n_in = 1; a_in = '1; b_in = '1;
    rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("release.start_ignored", busy, 1'b0);
    check("release.no_done", done, 1'b0);

    // 2x2x2 integer pattern scaled into Q8.8
    ma[0][0] = 16'h0100; ma[0][1] = 16'h0200; ma[1][0] = 16'h0300; ma[1][1] = 16'h0400;
    mb[0][0] = 16'h0500; mb[1][0] = 16'h0700; mb[0][1] = 16'h0600; mb[1][1] = 16'h0800;
    run_job(2, 2, 2, 1'b0, "mat2x2");
    check("mat2x2.const", result[63:0], {16'h3200, 16'h2B00, 16'h1600, 16'h1300});

    for (int x = 0; x < 6; x++) ma[x/3][x%3] = DW'((x+1) << FW);
    for (int k = 0; k < 3; k++) mb[k][0] = 16'h0100;
    run_job(2, 3, 1, 1'b0, "mat_vec");
    check("mat_vec.const", result[31:0], {16'h0F00, 16'h0600});

    ma[0][0] = 16'h7F00; mb[0][0] = 16'h0200;
    run_job(1, 1, 1, 1'b0, "pos_ovf");
`ifdef MATMUL_SAT_EN
    check("pos_ovf.const", result[15:0], 16'h7FFF);
`else
    check("pos_ovf.const", result[15:0], 16'hFE00);
`endif
    ma[0][0] = 16'h8000; mb[0][0] = 16'h0200;
    run_job(1, 1, 1, 1'b0, "neg_ovf");
`ifdef MATMUL_SAT_EN
    check("neg_ovf.const", result[15:0], 16'h8000);
`else
    check("neg_ovf.const", result[15:0], 16'h0000);
`endif

    fill_random();
    run_job(3, 3, 3, 1'b0, "full");
    run_job(0, 2, 2, 1'b0, "err_l0");
    run_job(2, MB+1, 1, 1'b0, "err_m");
    run_job(1, 1, 0, 1'b0, "err_n0");
    run_job(LB+1, 1, 1, 1'b0, "err_l");

    for (int t = 0; t < 20; t++) begin
      fill_random();
      run_job($urandom_range(1, LB), $urandom_range(1, MB), $urandom_range(1, NB), 1'b0, "rand");
    end

    fill_random();
    run_job(3, 3, 3, 1'b1, "disturb");

    fill_random();
    @(negedge clk);
    l_in = 3; m_in = 3; n_in = 3;
    pack(3, 3, 3, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort.result", result, '0);
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.err", err, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort.no_done", done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    fill_random();
    run_job(3, 2, 2, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
